// File: rtl/alu_op_sequencer.sv
// Issue stage in front of a combinational 32-bit ALU: reads operands from an 8-entry register file,
// holds them for one EXEC cycle, captures S/Cout, writes S back, and offers the result on a valid/ready port.
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [2:0]       inst_sel,
  input  logic             inst_cin,
  input  logic [AW-1:0]    inst_rs1,
  input  logic [AW-1:0]    inst_rs2,
  input  logic [AW-1:0]    inst_rd,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_S,
  input  logic             alu_Cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic [AW-1:0]    res_rd,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             issue, exec;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] rf [NREG];

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    inst_ready = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    issue      = 1'b0;
    exec       = 1'b0;
    case (state_q)
      IDLE: begin
        inst_ready = 1'b1;
        busy       = 1'b0;
        issue      = inst_valid;
        if (inst_valid) state_d = EXEC;
      end
      EXEC: begin
        exec    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writeback is assigned after the host load so it wins on an address collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (load_en) rf[load_addr] <= load_data;
      if (exec)    rf[rd_q]      <= alu_S;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_A    <= '0;
      alu_B    <= '0;
      alu_sel  <= '0;
      alu_cin  <= 1'b0;
      rd_q     <= '0;
      res_data <= '0;
      res_cout <= 1'b0;
      res_rd   <= '0;
    end else begin
      if (issue) begin
        alu_A   <= rf[inst_rs1];
        alu_B   <= rf[inst_rs2];
        alu_sel <= inst_sel;
        alu_cin <= inst_cin;
        rd_q    <= inst_rd;
      end
      if (exec) begin
        res_data <= alu_S;
        res_cout <= alu_Cout;
        res_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU (sel 0: A+B+cin, 1: A-B, 3: A<<B).
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset, load_en, inst_valid, inst_cin, res_ready;
  logic [2:0]  load_addr, inst_rs1, inst_rs2, inst_rd, inst_sel;
  logic [31:0] load_data;
  logic        inst_ready, alu_cin, alu_Cout, res_valid, res_cout, busy;
  logic [2:0]  alu_sel, res_rd;
  logic [31:0] alu_A, alu_B, alu_S, res_data;
  logic [32:0] sum33;

  int vectors = 0;
  int miscompares = 0;
  int accepted;

  always #5 clock = ~clock;

  assign sum33 = {1'b0, alu_A} + {1'b0, alu_B} + {32'd0, alu_cin};
  always_comb begin
    alu_S    = 32'd0;
    alu_Cout = 1'b0;
    case (alu_sel)
      3'd0: begin alu_S = sum33[31:0]; alu_Cout = sum33[32]; end
      3'd1: alu_S = alu_A - alu_B;
      3'd2: alu_S = alu_A & alu_B;
      3'd3: alu_S = alu_A << alu_B;
      default: alu_S = alu_A ^ alu_B;
    endcase
  end

  alu_op_sequencer #(.WIDTH(32), .NREG(8), .AW(3)) dut (
    .clock(clock), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_sel(inst_sel), .inst_cin(inst_cin),
    .inst_rs1(inst_rs1), .inst_rs2(inst_rs2), .inst_rd(inst_rd),
    .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_S(alu_S), .alu_Cout(alu_Cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_rd(res_rd), .busy(busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] sel, input logic cin,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd);
    inst_valid = 1'b1; inst_sel = sel; inst_cin = cin;
    inst_rs1 = rs1; inst_rs2 = rs2; inst_rd = rd;
    tick();
    inst_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = 3'd0; load_data = 32'd0;
    inst_valid = 1'b0; inst_sel = 3'd0; inst_cin = 1'b0;
    inst_rs1 = 3'd0; inst_rs2 = 3'd0; inst_rd = 3'd0; res_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_alu_A", alu_A, 32'd0);
    chk("rst_alu_B", alu_B, 32'd0);
    chk("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
    chk("rst_alu_cin", {31'd0, alu_cin}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_cout", {31'd0, res_cout}, 32'd0);
    chk("rst_res_rd", {29'd0, res_rd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // 290 + 101 + 1 with the consumer stalling in RESP
    load(3'd1, 32'd290);
    load(3'd2, 32'd101);
    issue(3'd0, 1'b1, 3'd1, 3'd2, 3'd3);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_ready", {31'd0, inst_ready}, 32'd0);
    chk("exec_alu_A", alu_A, 32'd290);
    chk("exec_alu_B", alu_B, 32'd101);
    chk("exec_alu_cin", {31'd0, alu_cin}, 32'd1);
    chk("exec_res_valid", {31'd0, res_valid}, 32'd0);
    tick();
    chk("add_res_valid", {31'd0, res_valid}, 32'd1);
    chk("add_res_data", res_data, 32'd392);
    chk("add_res_rd", {29'd0, res_rd}, 32'd3);
    chk("add_res_cout", {31'd0, res_cout}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_res_data", res_data, 32'd392);
      chk("stall_inst_ready", {31'd0, inst_ready}, 32'd0);
      chk("stall_alu_A", alu_A, 32'd290);
    end
    res_ready = 1'b1;
    tick();
    chk("release_res_valid", {31'd0, res_valid}, 32'd0);
    chk("release_inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd0);
    chk("hold_alu_B", alu_B, 32'd101);

    issue(3'd0, 1'b0, 3'd3, 3'd0, 3'd7);
    chk("wb_r3_alu_A", alu_A, 32'd392);
    chk("wb_r0_alu_B", alu_B, 32'd0);
    tick(); tick();

    // Shift with a colliding host load at the EXEC edge
    load(3'd4, 32'd1024);
    load(3'd5, 32'd7);
    res_ready = 1'b0;
    issue(3'd3, 1'b0, 3'd4, 3'd5, 3'd4);
    load(3'd4, 32'd55);
    chk("shl_res_data", res_data, 32'd131072);
    chk("shl_res_rd", {29'd0, res_rd}, 32'd4);
    res_ready = 1'b1;
    tick();
    issue(3'd0, 1'b0, 3'd4, 3'd0, 3'd7);
    chk("collide_r4", alu_A, 32'd131072);
    tick(); tick();

    // Back-to-back offers: one acceptance every third cycle
    accepted = 0;
    inst_valid = 1'b1; inst_sel = 3'd0; inst_cin = 1'b0;
    inst_rs1 = 3'd1; inst_rs2 = 3'd2; inst_rd = 3'd5;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_ready", {31'd0, inst_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
      if (inst_ready) accepted++;
      tick();
    end
    inst_valid = 1'b0;
    chk("b2b_accepted", accepted, 32'd3);
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // rs1 == rs2 == rd subtract
    load(3'd6, 32'd101);
    issue(3'd1, 1'b0, 3'd6, 3'd6, 3'd6);
    chk("same_alu_A", alu_A, 32'd101);
    chk("same_alu_B", alu_B, 32'd101);
    tick();
    chk("sub_res_data", res_data, 32'd0);
    tick();
    issue(3'd0, 1'b0, 3'd6, 3'd1, 3'd7);
    chk("r6_zero", alu_A, 32'd0);
    chk("r1_kept", alu_B, 32'd290);
    tick(); tick();

    // Carry-out
    load(3'd1, 32'hFFFF_FFFF);
    load(3'd2, 32'd1);
    issue(3'd0, 1'b0, 3'd1, 3'd2, 3'd7);
    tick();
    chk("carry_res_data", res_data, 32'd0);
    chk("carry_res_cout", {31'd0, res_cout}, 32'd1);
    tick();

    // Reset during EXEC aborts the instruction and clears the register file
    res_ready = 1'b0;
    issue(3'd0, 1'b0, 3'd1, 3'd2, 3'd2);
    chk("abort_in_exec", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_alu_A", alu_A, 32'd0);
    tick();
    chk("abort_res_valid_later", {31'd0, res_valid}, 32'd0);
    chk("abort_inst_ready", {31'd0, inst_ready}, 32'd1);
    res_ready = 1'b1;
    issue(3'd0, 1'b1, 3'd2, 3'd1, 3'd3);
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    chk("post_rst_r2", alu_A, 32'd0);
    chk("post_rst_r1", alu_B, 32'd0);
    tick();
    chk("post_rst_res_valid", {31'd0, res_valid}, 32'd1);
    chk("post_rst_res_data", res_data, 32'd1);
    tick();
    chk("post_rst_done", {31'd0, res_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
